// File: rtl/art_fault_queue.sv
// art_fault_queue: collects one-cycle miss/permission fault pulses from the
// I-side and D-side ART checkers into per-side pending slots, moves them into a
// small FIFO (one per cycle, D first then round-robin), acknowledges the
// checker one cycle after its record enters the FIFO, and lets software drain
// records through a pop port. A level interrupt flags a non-empty queue.
// Optional feature macro: ART_FAULT_TS_EN adds a 16-bit capture timestamp per
// record; without it o_Rec_Ts is tied to zero.
module art_fault_queue #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  i_I_Miss_Fault,
    input  logic                  i_I_Perm_Fault,
    input  logic [ADDR_W-1:0]     i_I_Addr,
    input  logic                  i_I_Priv,
    output logic                  o_I_Fault_Ack,
    input  logic                  i_D_Miss_Fault,
    input  logic                  i_D_Perm_Fault,
    input  logic [ADDR_W-1:0]     i_D_Addr,
    input  logic                  i_D_Priv,
    input  logic                  i_D_Wr,
    output logic                  o_D_Fault_Ack,
    input  logic                  i_Pop,
    output logic                  o_Rec_Valid,
    output logic                  o_Rec_Src,
    output logic                  o_Rec_Miss,
    output logic                  o_Rec_Wr,
    output logic                  o_Rec_Priv,
    output logic [ADDR_W-1:0]     o_Rec_Addr,
    output logic [15:0]           o_Rec_Ts,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef ART_FAULT_TS_EN
    localparam int REC_W = ADDR_W + 20;
`else
    localparam int REC_W = ADDR_W + 4;
`endif
    // Record layout: {[ts], src, miss, wr, priv, addr}
    localparam int A_PRIV = ADDR_W;
    localparam int A_WR   = ADDR_W + 1;
    localparam int A_MISS = ADDR_W + 2;
    localparam int A_SRC  = ADDR_W + 3;
`ifdef ART_FAULT_TS_EN
    localparam int A_TS   = ADDR_W + 4;
`endif
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    // Pending slots
    logic              pend_i_valid_q, pend_i_valid_d;
    logic              pend_i_miss_q,  pend_i_miss_d;
    logic              pend_i_priv_q,  pend_i_priv_d;
    logic [ADDR_W-1:0] pend_i_addr_q,  pend_i_addr_d;
    logic              pend_d_valid_q, pend_d_valid_d;
    logic              pend_d_miss_q,  pend_d_miss_d;
    logic              pend_d_priv_q,  pend_d_priv_d;
    logic              pend_d_wr_q,    pend_d_wr_d;
    logic [ADDR_W-1:0] pend_d_addr_q,  pend_d_addr_d;
`ifdef ART_FAULT_TS_EN
    logic [15:0]       pend_i_ts_q, pend_i_ts_d;
    logic [15:0]       pend_d_ts_q, pend_d_ts_d;
    logic [15:0]       ts_cnt_q,    ts_cnt_d;
`endif

    // Arbitration, acks and FIFO
    logic                  rr_i_q, rr_i_d;       // 1: I preferred when both pending
    logic                  ack_i_q, ack_i_d;
    logic                  ack_d_q, ack_d_d;
    logic [REC_W-1:0]      mem_q [DEPTH];
    logic [REC_W-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic [REC_W-1:0]      head_q,   head_d;
    logic                  valid_q,  valid_d;

    logic                  pop_fire_s, can_push_s, push_s, sel_d_s, both_s;
    logic [REC_W-1:0]      push_rec_s;

    // Next-state logic: capture, arbitration/transfer, FIFO pointers and head
    always_comb begin
        pop_fire_s = i_Pop && (count_q != CNT_ZERO);
        can_push_s = (count_q != FULL_CNT) || pop_fire_s;
        both_s     = pend_i_valid_q && pend_d_valid_q;

        if (both_s) begin
            sel_d_s = !rr_i_q;
        end else begin
            sel_d_s = pend_d_valid_q;
        end
        push_s = can_push_s && (pend_i_valid_q || pend_d_valid_q);

        push_rec_s = '0;
        if (sel_d_s) begin
            push_rec_s[ADDR_W-1:0] = pend_d_addr_q;
            push_rec_s[A_PRIV]     = pend_d_priv_q;
            push_rec_s[A_WR]       = pend_d_wr_q;
            push_rec_s[A_MISS]     = pend_d_miss_q;
            push_rec_s[A_SRC]      = 1'b1;
`ifdef ART_FAULT_TS_EN
            push_rec_s[A_TS +: 16] = pend_d_ts_q;
`endif
        end else begin
            push_rec_s[ADDR_W-1:0] = pend_i_addr_q;
            push_rec_s[A_PRIV]     = pend_i_priv_q;
            push_rec_s[A_WR]       = 1'b0;
            push_rec_s[A_MISS]     = pend_i_miss_q;
            push_rec_s[A_SRC]      = 1'b0;
`ifdef ART_FAULT_TS_EN
            push_rec_s[A_TS +: 16] = pend_i_ts_q;
`endif
        end

        // Round-robin pointer only moves when both sides competed
        if (push_s && both_s) begin
            rr_i_d = sel_d_s;
        end else begin
            rr_i_d = rr_i_q;
        end
        ack_d_d = push_s && sel_d_s;
        ack_i_d = push_s && !sel_d_s;

`ifdef ART_FAULT_TS_EN
        ts_cnt_d    = ts_cnt_q + 16'd1;
        pend_i_ts_d = pend_i_ts_q;
        pend_d_ts_d = pend_d_ts_q;
`endif

        // I-side slot: empties on transfer; pulses while full are ignored
        pend_i_valid_d = pend_i_valid_q;
        pend_i_miss_d  = pend_i_miss_q;
        pend_i_priv_d  = pend_i_priv_q;
        pend_i_addr_d  = pend_i_addr_q;
        if (push_s && !sel_d_s) begin
            pend_i_valid_d = 1'b0;
        end else if (!pend_i_valid_q && (i_I_Miss_Fault || i_I_Perm_Fault)) begin
            pend_i_valid_d = 1'b1;
            pend_i_miss_d  = i_I_Miss_Fault;
            pend_i_priv_d  = i_I_Priv;
            pend_i_addr_d  = i_I_Addr;
`ifdef ART_FAULT_TS_EN
            pend_i_ts_d    = ts_cnt_q;
`endif
        end else begin
            pend_i_valid_d = pend_i_valid_q;
        end

        // D-side slot: same rules, plus the write flag
        pend_d_valid_d = pend_d_valid_q;
        pend_d_miss_d  = pend_d_miss_q;
        pend_d_priv_d  = pend_d_priv_q;
        pend_d_wr_d    = pend_d_wr_q;
        pend_d_addr_d  = pend_d_addr_q;
        if (push_s && sel_d_s) begin
            pend_d_valid_d = 1'b0;
        end else if (!pend_d_valid_q && (i_D_Miss_Fault || i_D_Perm_Fault)) begin
            pend_d_valid_d = 1'b1;
            pend_d_miss_d  = i_D_Miss_Fault;
            pend_d_priv_d  = i_D_Priv;
            pend_d_wr_d    = i_D_Wr;
            pend_d_addr_d  = i_D_Addr;
`ifdef ART_FAULT_TS_EN
            pend_d_ts_d    = ts_cnt_q;
`endif
        end else begin
            pend_d_valid_d = pend_d_valid_q;
        end

        // FIFO storage and pointers
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_rec_s;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_fire_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Registered head view: a lone pushed record becomes the head directly
        if (count_d == CNT_ZERO) begin
            head_d = '0;
        end else if (push_s && (count_d == CNT_ONE)) begin
            head_d = push_rec_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        valid_d = (count_d != CNT_ZERO);
    end

    // State registers with synchronous reset; reset issues no acks
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_i_valid_q <= 1'b0;
            pend_i_miss_q  <= 1'b0;
            pend_i_priv_q  <= 1'b0;
            pend_i_addr_q  <= '0;
            pend_d_valid_q <= 1'b0;
            pend_d_miss_q  <= 1'b0;
            pend_d_priv_q  <= 1'b0;
            pend_d_wr_q    <= 1'b0;
            pend_d_addr_q  <= '0;
            rr_i_q         <= 1'b0;
            ack_i_q        <= 1'b0;
            ack_d_q        <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            head_q         <= '0;
            valid_q        <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
`ifdef ART_FAULT_TS_EN
            ts_cnt_q       <= 16'd0;
            pend_i_ts_q    <= 16'd0;
            pend_d_ts_q    <= 16'd0;
`endif
        end else begin
            pend_i_valid_q <= pend_i_valid_d;
            pend_i_miss_q  <= pend_i_miss_d;
            pend_i_priv_q  <= pend_i_priv_d;
            pend_i_addr_q  <= pend_i_addr_d;
            pend_d_valid_q <= pend_d_valid_d;
            pend_d_miss_q  <= pend_d_miss_d;
            pend_d_priv_q  <= pend_d_priv_d;
            pend_d_wr_q    <= pend_d_wr_d;
            pend_d_addr_q  <= pend_d_addr_d;
            rr_i_q         <= rr_i_d;
            ack_i_q        <= ack_i_d;
            ack_d_q        <= ack_d_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            head_q         <= head_d;
            valid_q        <= valid_d;
            mem_q          <= mem_d;
`ifdef ART_FAULT_TS_EN
            ts_cnt_q       <= ts_cnt_d;
            pend_i_ts_q    <= pend_i_ts_d;
            pend_d_ts_q    <= pend_d_ts_d;
`endif
        end
    end

    assign o_I_Fault_Ack = ack_i_q;
    assign o_D_Fault_Ack = ack_d_q;
    assign o_Rec_Valid   = valid_q;
    assign o_Irq         = valid_q;
    assign o_Rec_Src     = head_q[A_SRC];
    assign o_Rec_Miss    = head_q[A_MISS];
    assign o_Rec_Wr      = head_q[A_WR];
    assign o_Rec_Priv    = head_q[A_PRIV];
    assign o_Rec_Addr    = head_q[ADDR_W-1:0];
    assign o_Count       = count_q;
`ifdef ART_FAULT_TS_EN
    assign o_Rec_Ts      = head_q[A_TS +: 16];
`else
    assign o_Rec_Ts      = 16'h0000;
`endif

endmodule

// File: tb/tb_art_fault_queue.sv
// Bench for art_fault_queue: a directed vector table, hand-written full-FIFO
// and reset sequences, and randomized traffic checked every cycle against a
// queue-based reference model.
module tb_art_fault_queue;
    localparam int ADDR_W     = 32;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        i_I_Miss_Fault, i_I_Perm_Fault, i_I_Priv;
    logic [31:0] i_I_Addr;
    logic        i_D_Miss_Fault, i_D_Perm_Fault, i_D_Priv, i_D_Wr;
    logic [31:0] i_D_Addr;
    logic        i_Pop;
    logic        o_I_Fault_Ack, o_D_Fault_Ack, o_Rec_Valid, o_Rec_Src;
    logic        o_Rec_Miss, o_Rec_Wr, o_Rec_Priv, o_Irq;
    logic [31:0] o_Rec_Addr;
    logic [15:0] o_Rec_Ts;
    logic [2:0]  o_Count;

    always #5 Clk = ~Clk;

    art_fault_queue #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .Clk(Clk), .Reset(Reset),
        .i_I_Miss_Fault(i_I_Miss_Fault), .i_I_Perm_Fault(i_I_Perm_Fault),
        .i_I_Addr(i_I_Addr), .i_I_Priv(i_I_Priv), .o_I_Fault_Ack(o_I_Fault_Ack),
        .i_D_Miss_Fault(i_D_Miss_Fault), .i_D_Perm_Fault(i_D_Perm_Fault),
        .i_D_Addr(i_D_Addr), .i_D_Priv(i_D_Priv), .i_D_Wr(i_D_Wr),
        .o_D_Fault_Ack(o_D_Fault_Ack), .i_Pop(i_Pop),
        .o_Rec_Valid(o_Rec_Valid), .o_Rec_Src(o_Rec_Src), .o_Rec_Miss(o_Rec_Miss),
        .o_Rec_Wr(o_Rec_Wr), .o_Rec_Priv(o_Rec_Priv), .o_Rec_Addr(o_Rec_Addr),
        .o_Rec_Ts(o_Rec_Ts), .o_Count(o_Count), .o_Irq(o_Irq)
    );

    typedef struct packed {
        logic        src;
        logic        miss;
        logic        wr;
        logic        priv;
        logic [31:0] addr;
        logic [15:0] ts;
    } rec_t;

    // Reference model state: index 0 = I side, 1 = D side
    rec_t        q[$];
    bit          pv[2];
    rec_t        pr[2];
    bit          prefer_d;
    bit          m_ack[2];
    logic [15:0] ts_m;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge of the spec-level behaviour
    task automatic model_step();
        bit   pop_fire, room, both;
        bit   pv_old[2];
        int   win;
        if (Reset) begin
            q.delete();
            pv[0] = 1'b0; pv[1] = 1'b0;
            m_ack[0] = 1'b0; m_ack[1] = 1'b0;
            prefer_d = 1'b1;
            ts_m = 16'h0;
        end else begin
            pv_old   = pv;
            pop_fire = i_Pop && (q.size() > 0);
            room     = (q.size() < DEPTH) || pop_fire;
            both     = pv[0] && pv[1];
            win      = both ? (prefer_d ? 1 : 0) : (pv[1] ? 1 : 0);
            m_ack[0] = 1'b0; m_ack[1] = 1'b0;
            if (pop_fire) void'(q.pop_front());
            if ((pv[0] || pv[1]) && room) begin
                q.push_back(pr[win]);
                pv[win]    = 1'b0;
                m_ack[win] = 1'b1;
                if (both) prefer_d = (win == 0);
            end
            if (!pv_old[0] && (i_I_Miss_Fault || i_I_Perm_Fault)) begin
                pv[0] = 1'b1;
                pr[0].src = 1'b0; pr[0].miss = i_I_Miss_Fault; pr[0].wr = 1'b0;
                pr[0].priv = i_I_Priv; pr[0].addr = i_I_Addr; pr[0].ts = ts_m;
            end
            if (!pv_old[1] && (i_D_Miss_Fault || i_D_Perm_Fault)) begin
                pv[1] = 1'b1;
                pr[1].src = 1'b1; pr[1].miss = i_D_Miss_Fault; pr[1].wr = i_D_Wr;
                pr[1].priv = i_D_Priv; pr[1].addr = i_D_Addr; pr[1].ts = ts_m;
            end
            ts_m = ts_m + 16'd1;
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {5'b0, o_I_Fault_Ack, o_D_Fault_Ack, o_Rec_Valid, o_Rec_Src, o_Rec_Miss,
                o_Rec_Wr, o_Rec_Priv, o_Rec_Addr, o_Rec_Ts, o_Count, o_Irq};
    endfunction

    function automatic logic [63:0] model_vec();
        rec_t        h;
        logic        v;
        logic [15:0] tsx;
        logic [2:0]  cnt;
        h   = '0;
        v   = (q.size() > 0);
        if (v) h = q[0];
`ifdef ART_FAULT_TS_EN
        tsx = h.ts;
`else
        tsx = 16'h0;
`endif
        cnt = 3'(q.size());
        return {5'b0, m_ack[0], m_ack[1], v, h.src, h.miss, h.wr, h.priv, h.addr, tsx, cnt, v};
    endfunction

    // Inputs are set at the falling edge; the DUT and model consume them at the
    // rising edge; results are compared at the next falling edge.
    task automatic cyc();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic idle();
        i_I_Miss_Fault = 1'b0; i_I_Perm_Fault = 1'b0; i_I_Priv = 1'b0; i_I_Addr = 32'h0;
        i_D_Miss_Fault = 1'b0; i_D_Perm_Fault = 1'b0; i_D_Priv = 1'b0; i_D_Wr = 1'b0;
        i_D_Addr = 32'h0; i_Pop = 1'b0;
    endtask

    // Raise a D perm fault and wait (bounded) for its ack
    task automatic d_fault_wait_ack(input logic [31:0] addr);
        bit seen;
        seen = 1'b0;
        i_D_Perm_Fault = 1'b1; i_D_Addr = addr; i_D_Wr = addr[8];
        cyc();
        idle();
        for (int t = 0; t < 6 && !seen; t++) begin
            cyc();
            seen = o_D_Fault_Ack;
        end
        check("fill_ack", 64'(seen), 64'd1);
    endtask

    typedef struct {
        logic        im, ip;
        logic [31:0] ia;
        logic        ipv;
        logic        dm, dp;
        logic [31:0] da;
        logic        dpv, dw, pop;
        logic [41:0] exp;   // {ack_i, ack_d, valid, src, miss, wr, priv, addr, count}
    } vec_t;

    function automatic vec_t mkrow(input logic im, input logic ip, input logic [31:0] ia,
                                   input logic ipv, input logic dm, input logic dp,
                                   input logic [31:0] da, input logic dpv, input logic dw,
                                   input logic pop, input logic eai, input logic ead,
                                   input logic ev, input logic es, input logic em,
                                   input logic ew, input logic ep, input logic [31:0] eaddr,
                                   input logic [2:0] ecnt);
        vec_t r;
        r.im = im; r.ip = ip; r.ia = ia; r.ipv = ipv;
        r.dm = dm; r.dp = dp; r.da = da; r.dpv = dpv; r.dw = dw; r.pop = pop;
        r.exp = {eai, ead, ev, es, em, ew, ep, eaddr, ecnt};
        return r;
    endfunction

    vec_t        vt[12];
    logic [31:0] exp_addr[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: single D perm fault, simultaneous I/D, miss+perm on I
        vt[0]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b1,32'h8000_1234,1'b0,1'b1,1'b0,
                       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,3'd0);
        vt[1]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                       1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,32'h8000_1234,3'd1);
        vt[2]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                       1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,32'h8000_1234,3'd1);
        vt[3]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,
                       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,3'd0);
        vt[4]  = mkrow(1'b1,1'b0,32'h1000_0004,1'b1, 1'b0,1'b1,32'h2000_0008,1'b1,1'b0,1'b0,
                       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,3'd0);
        vt[5]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                       1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,32'h2000_0008,3'd1);
        vt[6]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                       1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'h2000_0008,3'd2);
        vt[7]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,
                       1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,32'h1000_0004,3'd1);
        vt[8]  = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,
                       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,3'd0);
        vt[9]  = mkrow(1'b1,1'b1,32'h0000_00AA,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,3'd0);
        vt[10] = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                       1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_00AA,3'd1);
        vt[11] = mkrow(1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,
                       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,3'd0);

        idle();
        Reset = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < 3; k++) cyc();
        check("reset_state", dut_vec(), 64'h0);
        Reset = 1'b0;
        cyc();

        for (int k = 0; k < 12; k++) begin
            i_I_Miss_Fault = vt[k].im; i_I_Perm_Fault = vt[k].ip;
            i_I_Addr = vt[k].ia; i_I_Priv = vt[k].ipv;
            i_D_Miss_Fault = vt[k].dm; i_D_Perm_Fault = vt[k].dp;
            i_D_Addr = vt[k].da; i_D_Priv = vt[k].dpv; i_D_Wr = vt[k].dw;
            i_Pop = vt[k].pop;
            cyc();
            check($sformatf("vec%0d", k),
                  64'({o_I_Fault_Ack, o_D_Fault_Ack, o_Rec_Valid, o_Rec_Src, o_Rec_Miss,
                       o_Rec_Wr, o_Rec_Priv, o_Rec_Addr, o_Count}),
                  64'(vt[k].exp));
            check($sformatf("vec%0d_irq", k), 64'(o_Irq), 64'(vt[k].exp[39]));
        end
        idle();

        // Full FIFO blocks an I fault; a single pop lets it in the same edge
        for (int k = 1; k <= 4; k++) d_fault_wait_ack(32'h100 * k);
        check("full_cnt", 64'(o_Count), 64'd4);
        i_I_Miss_Fault = 1'b1; i_I_Addr = 32'h500;
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("full_no_ack", 64'(o_I_Fault_Ack), 64'd0);
            check("full_hold_cnt", 64'(o_Count), 64'd4);
        end
        i_Pop = 1'b1;
        cyc();
        idle();
        check("pushpop_ack", 64'(o_I_Fault_Ack), 64'd1);
        check("pushpop_cnt", 64'(o_Count), 64'd4);
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h300; exp_addr[2] = 32'h400; exp_addr[3] = 32'h500;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("order%0d", k), 64'(o_Rec_Addr), 64'(exp_addr[k]));
            i_Pop = 1'b1;
            cyc();
        end
        idle();
        check("drained_irq", 64'(o_Irq), 64'd0);

        // Full FIFO with I pending, pop held for five cycles drains to empty
        for (int k = 6; k <= 9; k++) d_fault_wait_ack(32'h100 * k);
        i_I_Perm_Fault = 1'b1; i_I_Addr = 32'hA00;
        cyc();
        idle();
        cyc();
        i_Pop = 1'b1;
        cyc();
        check("hold_pop_ack", 64'(o_I_Fault_Ack), 64'd1);
        check("hold_pop_cnt", 64'(o_Count), 64'd4);
        for (int k = 0; k < 4; k++) cyc();
        idle();
        check("hold_pop_empty", 64'(o_Count), 64'd0);
        check("hold_pop_irq", 64'(o_Irq), 64'd0);

        // Reset mid-queue: records plus a pending slot vanish without an ack
        i_D_Miss_Fault = 1'b1; i_D_Addr = 32'hCAFE_0000;
        i_I_Miss_Fault = 1'b1; i_I_Addr = 32'hBEEF_0000;
        cyc();
        idle();
        for (int k = 0; k < 3; k++) cyc();
        i_D_Perm_Fault = 1'b1; i_D_Addr = 32'hD00D_0000;
        cyc();
        idle();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("rst_mid_cnt", 64'(o_Count), 64'd0);
        check("rst_mid_out", dut_vec(), 64'h0);
        cyc();
        check("rst_mid_noack", 64'({o_I_Fault_Ack, o_D_Fault_Ack}), 64'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            i_I_Miss_Fault = ($urandom_range(5) == 0);
            i_I_Perm_Fault = ($urandom_range(5) == 0);
            i_I_Addr       = $urandom;
            i_I_Priv       = $urandom_range(1) == 1;
            i_D_Miss_Fault = ($urandom_range(5) == 0);
            i_D_Perm_Fault = ($urandom_range(4) == 0);
            i_D_Addr       = $urandom;
            i_D_Priv       = $urandom_range(1) == 1;
            i_D_Wr         = $urandom_range(1) == 1;
            i_Pop          = ((n / 200) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(2) != 0);
            Reset          = ($urandom_range(699) == 0);
            cyc();
        end
        Reset = 1'b0;
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/art_fault_queue.md
Name: art_fault_queue

Overview:
- Sits downstream of the I-side and D-side ART permission/miss checkers.
- Captures each one-cycle miss or permission fault pulse, along with the faulting address and access attributes, into a per-side pending slot.
- Moves pending records into a small FIFO, then returns the fault acknowledge that releases the checker from its fault-service state.
- Software drains the FIFO through a pop port; a level interrupt flags a non-empty queue.

Parameters:
ADDR_W, 32, width of the captured faulting address
DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4)

Ports:
Clk  in  1  clock
Reset  in  1  synchronous active-high reset
i_I_Miss_Fault  in  1  I-side miss fault pulse
i_I_Perm_Fault  in  1  I-side permission fault pulse
i_I_Addr  in  ADDR_W  I-side faulting address, valid with fault pulse
i_I_Priv  in  1  I-side privileged mode, valid with fault pulse
o_I_Fault_Ack  out  1  one-cycle acknowledge to I-side checker
i_D_Miss_Fault  in  1  D-side miss fault pulse
i_D_Perm_Fault  in  1  D-side permission fault pulse
i_D_Addr  in  ADDR_W  D-side faulting address
i_D_Priv  in  1  D-side privileged mode
i_D_Wr  in  1  D-side write operation flag
o_D_Fault_Ack  out  1  one-cycle acknowledge to D-side checker
i_Pop  in  1  software pop of head record
o_Rec_Valid  out  1  FIFO non-empty; head record valid
o_Rec_Src  out  1  head source: 0=I, 1=D
o_Rec_Miss  out  1  head type: 1=miss, 0=permission
o_Rec_Wr  out  1  head write flag (always 0 for I)
o_Rec_Priv  out  1  head privileged flag
o_Rec_Addr  out  ADDR_W  head faulting address
o_Rec_Ts  out  16  head timestamp (see optional feature)
o_Count  out  DEPTH_LOG2+1  FIFO occupancy
o_Irq  out  1  level interrupt, equals o_Rec_Valid

Behaviour:
- Reset: all outputs 0; FIFO empty; both pending slots empty; pointers 0.
- Pending slot per side:
  - On a fault pulse (miss OR perm) with the slot empty, latch addr, priv, wr, and miss at the next edge.
  - Miss has priority if both pulses are high; record miss=1.
  - A pulse while the slot is full is a protocol violation (the checker cannot re-fault before ack). Ignore it.
- Transfer:
  - Each cycle, at most one pending slot moves into the FIFO.
  - Requires count < depth, or a simultaneous pop while full.
  - Priority: D before I, round-robin toggled after each transfer when both are pending. The pointer resets to D.
- Ack: in the cycle after a transfer, the corresponding o_X_Fault_Ack is high for exactly one cycle, and that slot is empty.
  - Minimum latency, pulse to ack: 2 cycles (latch, transfer, ack registered).
  - A new pulse may be latched in the same cycle the ack is high.
- FIFO full with both slots pending: no transfer, no ack; the checkers stall in fault service. No record is ever dropped.
- Pop:
  - i_Pop with o_Rec_Valid: advance head at the edge; output fields show the next record (or 0 when empty) in the following cycle.
  - i_Pop while empty: ignored.
  - Push and pop in the same cycle: count unchanged; legal even when full.
- Pointers wrap modulo 2^DEPTH_LOG2; count ranges 0..depth.
- Output fields are driven from the head entry; they are don't-care-free (0) when empty.
- Reset mid-operation clears pending slots and the FIFO without issuing acks. The checkers reset on the same signal.

Optional Feature:
- ART_FAULT_TS_EN defined:
  - A free-running 16-bit cycle counter (reset 0, wraps at 0xFFFF→0) is sampled into the pending slot at pulse capture.
  - The sample is stored per FIFO entry and driven on o_Rec_Ts.
- Undefined: no counter or storage; o_Rec_Ts tied to 0.

Test Plan:
- D perm fault with addr 0x8000_1234, wr=1, priv=0 in an idle system: o_D_Fault_Ack pulses exactly 2 cycles after the pulse; o_Rec_Valid=1; Src=1, Miss=0, Wr=1, Addr=0x8000_1234; o_Irq=1; Count=1.
- I miss and D perm in the same cycle: D record enters first, then I. Acks appear on consecutive cycles (D, then I); Count=2; pop order D then I.
- Fill 4 records, then raise I fault:
  - no I ack while full; Count stays 4.
  - pop once → I ack 1 cycle after transfer; Count returns to 4.
  - record addresses are in order.
- Both miss and perm asserted together on I: record Miss=1.
- Full FIFO with one slot pending and i_Pop held for 5 cycles: a push and a pop occur in the same cycle; the FIFO then drains to empty; o_Irq=0 after the last pop.
- With ART_FAULT_TS_EN: faults at cycles 10 and 25 after reset yield Ts differing by 15. Counter wraps after cycle 65535. Reset mid-queue clears Count to 0 with no ack.
